branch_resolve_queue: RTL

In-order circular buffer holding one `BRANCH_PREDICTOR_PACKET` per in-flight conditional branch, from dispatch until resolution. It sits between dispatch/execute and the branch predictor. It receives the packets the predictor handed to fetch, tags each branch, and accepts out-of-order resolutions from execute. On each resolution it drives the predictor's update port (`bs_bp_packet`, `resolving_valid_branch`, `taken`, `mispred`) and squashes younger branches on a mispredict.

---
 rtl/branch_resolve_queue_pkg.sv | 23 ++
 rtl/branch_resolve_queue_lane.sv | 25 ++
 rtl/branch_resolve_queue.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolve queue: dispatch width, default depth,
// the predictor packet carried per branch and the per-entry record.
package branch_resolve_queue_pkg;

    localparam int N          = 4;
    localparam int BRQ_SZ_DEF = 8;
    localparam int BRQ_TAG_W  = $clog2(BRQ_SZ_DEF);

    typedef logic [BRQ_TAG_W-1:0] BRQ_TAG;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  ghist;
    } BRANCH_PREDICTOR_PACKET;

    typedef struct packed {
        logic                   valid;
        logic                   resolved;
        logic                   pred_taken;
        BRANCH_PREDICTOR_PACKET packet;
    } BRQ_ENTRY;

endpackage

// File: rtl/branch_resolve_queue_lane.sv
// Exclusive prefix popcount over a lane mask plus the total count.
// Used for dispatch-lane compaction and for contiguous-retire counting.
module lane_prefix_count #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]         mask,
    output logic [W-1:0][CW-1:0] prefix,
    output logic [CW-1:0]        total
);

    logic [CW-1:0] acc;

    // running sum: each lane sees the count of set lanes strictly below it
    always_comb begin
        acc    = '0;
        prefix = '0;
        for (int i = 0; i < W; i++) begin
            prefix[i] = acc;
            acc       = acc + CW'(mask[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order circular queue of in-flight conditional branches. Allocates tags at
// dispatch, accepts out-of-order resolutions, drives the predictor update port,
// squashes younger branches on a mispredict and retires resolved branches
// from the head in order.
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int BRQ_SZ = BRQ_SZ_DEF
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [N-1:0]                        alloc_valid,
    input  BRANCH_PREDICTOR_PACKET [N-1:0]      alloc_packets,
    input  logic [N-1:0]                        alloc_pred_taken,
    output logic [N-1:0][$clog2(BRQ_SZ)-1:0]    alloc_tags,
    output logic [$clog2(BRQ_SZ+1)-1:0]         free_count,
    input  logic                                resolve_valid,
    input  logic [$clog2(BRQ_SZ)-1:0]           resolve_tag,
    input  logic                                resolve_taken,
    output BRANCH_PREDICTOR_PACKET              bs_bp_packet,
    output logic                                resolving_valid_branch,
    output logic                                taken,
    output logic                                mispred,
    input  logic                                flush
);

    localparam int TW = $clog2(BRQ_SZ);
    localparam int PW = TW + 1;
    localparam int FW = $clog2(BRQ_SZ + 1);
    localparam int CW = $clog2(N + 1);

    BRQ_ENTRY entries     [BRQ_SZ];
    BRQ_ENTRY entries_nxt [BRQ_SZ];

    // pointers carry an extra wrap bit so full and empty are distinguishable
    logic [PW-1:0] head, tail, head_nxt, tail_nxt;
    logic [FW-1:0] free_nxt;

    logic [N-1:0][CW-1:0] alloc_prefix;
    logic [CW-1:0]        alloc_k;
    logic [N-1:0]         retire_ready;
    logic [N-1:0][CW-1:0] retire_prefix;
    logic [CW-1:0]        retire_total;
    logic [CW-1:0]        retire_cnt;

    BRQ_ENTRY             res_entry;
    logic                 res_ok, res_mis, squash, alloc_ok;
    logic [TW-1:0]        res_age;
    logic [BRQ_SZ-1:0]    kill, alloc_wr;

    lane_prefix_count #(.W(N), .CW(CW)) u_alloc_cnt (
        .mask   (alloc_valid),
        .prefix (alloc_prefix),
        .total  (alloc_k)
    );

    lane_prefix_count #(.W(N), .CW(CW)) u_retire_cnt (
        .mask   (retire_ready),
        .prefix (retire_prefix),
        .total  (retire_total)
    );

    // compacted tags for the valid dispatch lanes, starting at tail
    always_comb begin
        for (int i = 0; i < N; i++)
            alloc_tags[i] = tail[TW-1:0] + TW'(alloc_prefix[i]);
    end

    // resolution qualification; flush drops the resolve and squash blocks allocation
    always_comb begin
        res_entry = entries[resolve_tag];
        res_ok    = resolve_valid && res_entry.valid && !res_entry.resolved && !flush;
        res_mis   = resolve_taken ^ res_entry.pred_taken;
        squash    = res_ok && res_mis;
        res_age   = resolve_tag - head[TW-1:0];
        alloc_ok  = !flush && !squash && (FW'(alloc_k) <= free_count);
    end

    // head-window lanes that are valid and resolved, and the contiguous run length
    always_comb begin
        for (int i = 0; i < N; i++)
            retire_ready[i] = entries[head[TW-1:0] + TW'(i)].valid &&
                              entries[head[TW-1:0] + TW'(i)].resolved;
        retire_cnt = '0;
        if (retire_total == CW'(N)) begin
            retire_cnt = CW'(N);
        end else begin
            // a lane is part of the run only if every lane below it is ready too
            for (int i = 0; i < N; i++)
                if (retire_ready[i] && retire_prefix[i] == CW'(i))
                    retire_cnt = CW'(i + 1);
        end
    end

    // next entry contents and pointers: retire, resolve, squash, allocate, flush
    always_comb begin
        entries_nxt = entries;
        kill        = '0;
        alloc_wr    = '0;
        head_nxt    = head + PW'(retire_cnt);
        tail_nxt    = tail;

        for (int i = 0; i < N; i++)
            if (CW'(i) < retire_cnt)
                entries_nxt[head[TW-1:0] + TW'(i)] = '0;

        if (res_ok)
            entries_nxt[resolve_tag].resolved = 1'b1;

        if (squash) begin
            tail_nxt = head + PW'(res_age) + PW'(1);
            for (int j = 0; j < BRQ_SZ; j++)
                if (TW'(TW'(j) - head[TW-1:0]) > res_age)
                    kill[j] = 1'b1;
        end

        if (alloc_ok) begin
            tail_nxt = tail + PW'(alloc_k);
            for (int i = 0; i < N; i++) begin
                if (alloc_valid[i]) begin
                    entries_nxt[alloc_tags[i]].valid      = 1'b1;
                    entries_nxt[alloc_tags[i]].resolved   = 1'b0;
                    entries_nxt[alloc_tags[i]].pred_taken = alloc_pred_taken[i];
                    entries_nxt[alloc_tags[i]].packet     = alloc_packets[i];
                    alloc_wr[alloc_tags[i]]               = 1'b1;
                end
            end
        end

        if (flush) begin
            head_nxt = tail;
            tail_nxt = tail;
            kill     = '1;
        end

        for (int j = 0; j < BRQ_SZ; j++)
            if (kill[j])
                entries_nxt[j] = '0;

        free_nxt = FW'(BRQ_SZ) - FW'(tail_nxt - head_nxt);
    end

    // queue state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            free_count <= FW'(BRQ_SZ);
            entries    <= '{default: '0};
        end else begin
            head       <= head_nxt;
            tail       <= tail_nxt;
            free_count <= free_nxt;
            entries    <= entries_nxt;
        end
    end

    // predictor update port, one-cycle strobe per accepted resolution
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resolving_valid_branch <= 1'b0;
            taken                  <= 1'b0;
            mispred                <= 1'b0;
            bs_bp_packet           <= '0;
        end else begin
            resolving_valid_branch <= res_ok;
            taken                  <= res_ok && resolve_taken;
            mispred                <= squash;
            bs_bp_packet           <= res_ok ? res_entry.packet : '0;
        end
    end

`ifndef SYNTHESIS
    // slots emptied by squash/flush may still see late resolves from execute
    logic [BRQ_SZ-1:0] stale;

    // remember which free slots were vacated by a squash or flush
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stale <= '0;
        end else begin
            for (int j = 0; j < BRQ_SZ; j++) begin
                if (alloc_wr[j])
                    stale[j] <= 1'b0;
                else if (kill[j] && entries[j].valid)
                    stale[j] <= 1'b1;
            end
        end
    end

    a_resolve_live: assert property (@(posedge clock) disable iff (!reset)
        resolve_valid |-> ((entries[resolve_tag].valid && !entries[resolve_tag].resolved) ||
                           stale[resolve_tag]))
        else $error("branch_resolve_queue: resolve of free or already-resolved tag %0d", resolve_tag);
`endif

endmodule
